serial_as_nb: RTL and testbench

Bit-serial, multi-cycle add/subtract unit with a start/done handshake. It computes the same function as the team's combinational 4-bit adder/subtractor: `mode`=0 gives A+B, `mode`=1 gives A−B. It uses a single full-adder slice and processes one bit per clock, LSB first. It serves as the low-area arithmetic engine for control paths where latency is cheap, and as the sequential counterpart that exercises the team's add/sub test vectors over time.

---
 rtl/serial_as_nb.sv | 99 +++++++++
 tb/tb_serial_as_nb.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_as_nb.sv
// serial_as_nb: bit-serial add/subtract engine.
// One full-adder slice, LSB first, start/done handshake.
module serial_as_nb #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             c;
  logic             mode_q;
  logic             a_msb;
  logic             b_msb;

  logic             accept;
  logic             last;
  logic             sum;
  logic             c_next;
  logic [WIDTH-1:0] acc_next;
  logic             ovf_next;

  // Full-adder slice and handshake decode.
  always_comb begin
    accept   = start && (state == ST_IDLE || state == ST_DONE);
    last     = (cnt == CW'(WIDTH - 1));
    sum      = a_sr[0] ^ b_sr[0] ^ c;
    c_next   = (a_sr[0] & b_sr[0]) | (a_sr[0] & c) | (b_sr[0] & c);
    acc_next = {sum, acc[WIDTH-1:1]};
    if (mode_q)
      ovf_next = (a_msb != b_msb) && (sum != a_msb);
    else
      ovf_next = (a_msb == b_msb) && (sum != a_msb);
  end

  assign busy = (state == ST_SHIFT);
  assign done = (state == ST_DONE);

  // Control FSM, datapath shift and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      acc       <= '0;
      cnt       <= '0;
      c         <= 1'b0;
      mode_q    <= 1'b0;
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept) begin
      state  <= ST_SHIFT;
      a_sr   <= A;
      b_sr   <= B ^ {WIDTH{mode}};
      c      <= mode;
      mode_q <= mode;
      cnt    <= '0;
      a_msb  <= A[WIDTH-1];
      b_msb  <= B[WIDTH-1];
    end else if (state == ST_SHIFT) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      c    <= c_next;
      acc  <= acc_next;
      cnt  <= cnt + CW'(1);
      if (last) begin
        state     <= ST_DONE;
        result    <= acc_next;
        carry_out <= c_next ^ mode_q;
        overflow  <= ovf_next;
      end
    end else if (state == ST_DONE) begin
      state <= ST_IDLE;
    end
  end

endmodule

// File: tb/tb_serial_as_nb.sv
// tb_serial_as_nb: random + directed scoreboard bench
// for the bit-serial add/subtract unit.
module tb_serial_as_nb;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         v;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         mode;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;

  int n_checks;
  int n_fail;
  int n_pushed;
  int n_done;
  int cyc;
  logic [W-1:0] hold_r;
  logic prev_done;
  exp_t q[$];
  int done_cyc[$];

  serial_as_nb #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .A(A), .B(B), .mode(mode),
    .busy(busy), .done(done), .result(result),
    .carry_out(carry_out), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Reference: true-integer arithmetic, then reduce.
  function automatic exp_t model(input int a, input int b,
                                 input bit m);
    exp_t e;
    int full, sa, sb, sfull;
    full  = m ? a - b : a + b;
    sa    = (a >= 2**(W-1)) ? a - 2**W : a;
    sb    = (b >= 2**(W-1)) ? b - 2**W : b;
    sfull = m ? sa - sb : sa + sb;
    e.r   = W'(full & (2**W - 1));
    e.c   = m ? (a < b) : (full >= 2**W);
    e.v   = (sfull > 2**(W-1) - 1) || (sfull < -(2**(W-1)));
    return e;
  endfunction

  task automatic push(input int a, input int b, input bit m);
    q.push_back(model(a, b, m));
    n_pushed++;
  endtask

  // Issue one operation from IDLE and let it drain.
  task automatic do_op(input int a, input int b, input bit m);
    A = W'(a); B = W'(b); mode = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    push(a, b, m);
    A = W'($urandom); B = W'($urandom); mode = 1'($urandom);
    repeat (W + 1) @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (rst) begin
      hold_r    = '0;
      prev_done = 1'b0;
    end else begin
      chk("busy_done_excl", 32'(busy & done), 0);
      if (busy) chk("result_hold", 32'(result), 32'(hold_r));
      if (done) begin
        chk("done_single", 32'(prev_done), 0);
        chk("sb_nonempty", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          exp_t e;
          e = q.pop_front();
          chk("result", 32'(result), 32'(e.r));
          chk("carry_out", 32'(carry_out), 32'(e.c));
          chk("overflow", 32'(overflow), 32'(e.v));
        end
        hold_r = result;
        n_done++;
        done_cyc.push_back(cyc);
      end
      prev_done = done;
    end
  end

  initial begin
    int nd;
    int wait_n;
    n_checks = 0; n_fail = 0; n_pushed = 0; n_done = 0;
    cyc = 0; hold_r = '0; prev_done = 1'b0;
    rst = 1'b1; start = 1'b0; A = '0; B = '0; mode = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_carry", 32'(carry_out), 0);
    chk("rst_ovf", 32'(overflow), 0);
    @(posedge clk); #1;

    do_op(4'b0011, 4'b0101, 1'b0);
    do_op(4'b1100, 4'b0011, 1'b0);
    do_op(4'b1111, 4'b0001, 1'b0);
    do_op(4'b0101, 4'b0011, 1'b1);
    do_op(4'b1000, 4'b0110, 1'b1);
    do_op(4'b0011, 4'b0101, 1'b1);

    // Start pulse and operand changes during SHIFT.
    A = 4'b0011; B = 4'b0101; mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    push(4'b0011, 4'b0101, 1'b0);
    start = 1'b0; A = 4'b1111; B = 4'b1110; mode = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; A = 4'b0110;
    @(posedge clk); #1;
    start = 1'b0; B = 4'b0001;
    repeat (W) @(posedge clk);
    #1;

    // Back-to-back with start held through DONE.
    A = 4'b0101; B = 4'b0011; mode = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    push(4'b0101, 4'b0011, 1'b1);
    A = 4'b0001; B = 4'b0001; mode = 1'b0;
    for (int i = 0; i <= 2 * W; i++) begin
      @(negedge clk);
      chk("b2b_busy_or_done", 32'(busy | done), 1);
      @(posedge clk); #1;
      if (i == W) begin
        push(4'b0001, 4'b0001, 1'b0);
        start = 1'b0;
      end
    end
    repeat (2) @(posedge clk);
    #1;
    chk("b2b_spacing",
        32'(done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2]),
        32'(W + 1));

    // Asynchronous reset two edges into an operation.
    do_op(4'b0111, 4'b0110, 1'b0);
    A = 4'b0110; B = 4'b0111; mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_result", 32'(result), 0);
    chk("arst_carry", 32'(carry_out), 0);
    chk("arst_ovf", 32'(overflow), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    nd = n_done;
    repeat (W + 2) @(posedge clk);
    #1;
    chk("arst_no_done", 32'(n_done), 32'(nd));
    chk("arst_result_stays", 32'(result), 0);
    do_op(4'b0011, 4'b0101, 1'b0);

    // Random operations.
    for (int i = 0; i < 40; i++)
      do_op(int'($urandom_range(0, 2**W - 1)),
            int'($urandom_range(0, 2**W - 1)),
            1'($urandom));

    wait_n = 0;
    while (q.size() != 0 && wait_n < 20) begin
      @(posedge clk);
      wait_n++;
    end
    #1;
    chk("sb_drained", 32'(q.size()), 0);
    chk("done_count", 32'(n_done), 32'(n_pushed));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
